// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer
//   Writer side of the byte-wide instruction-register load interface. A fetch
//   request reads two consecutive bytes from an 8-bit memory (low byte first).
//   Each byte is presented to the IR with a one-cycle write strobe and a
//   half-select. The block then pulses Done and reports the next sequential PC.
//
//   Optional feature (macro FETCH_TIMEOUT_EN): each memory read is abandoned
//   after TIMEOUT cycles without MemValid. In that case Error pulses for one
//   cycle and the sequencer returns to IDLE. Without the macro the Error port
//   and the wait counter do not exist, and the sequencer waits indefinitely.
//
// Ports
//   Clock    in   rising-edge clock
//   Reset    in   synchronous, active-high reset
//   Start    in   fetch request, sampled only in IDLE
//   PCIn     in   [ADDR_W] address of the low instruction byte
//   MemAddr  out  [ADDR_W] memory read address
//   MemRead  out  memory read request, held until MemValid
//   MemData  in   [DATA_W] memory read data
//   MemValid in   read data valid, honoured only while MemRead=1
//   IRData   out  [DATA_W] byte driven to the IR input bus
//   IRWrite  out  one-cycle IR write strobe
//   IRLH     out  IR half-select (0 = low byte, 1 = high byte)
//   Busy     out  high in every non-IDLE state
//   Done     out  one-cycle completion pulse
//   NextPC   out  [ADDR_W] PCIn + 2 (mod 2^ADDR_W), updated with Done
//   Error    out  timeout pulse (FETCH_TIMEOUT_EN only)
module instruction_fetch_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] PCIn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemData,
  input  logic              MemValid,
  output logic [DATA_W-1:0] IRData,
  output logic              IRWrite,
  output logic              IRLH,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] NextPC
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic              Error
`endif
);

  if (DATA_W != 8) begin : g_bad_data_w
    $error("instruction_fetch_sequencer: DATA_W must be 8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("instruction_fetch_sequencer: TIMEOUT must be at least 1");
  end

  // The state register moves in lockstep with the registered outputs, so the
  // state value always names the phase the outputs currently show.
  // WR_HI spans two cycles: the high-byte strobe cycle and one quiet cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [ADDR_W-1:0] next_pc_nxt;
  logic [DATA_W-1:0] ir_data_nxt;
  logic              mem_read_nxt;
  logic              ir_write_nxt;
  logic              irlh_nxt;
  logic              busy_nxt;
  logic              done_nxt;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              error_nxt;
  logic              wait_expired;

  // True in the last permitted wait cycle of a read.
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    mem_addr_nxt = MemAddr;
    mem_read_nxt = MemRead;
    ir_data_nxt  = IRData;
    irlh_nxt     = IRLH;
    next_pc_nxt  = NextPC;
    ir_write_nxt = 1'b0;
    done_nxt     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt;
    error_nxt    = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt    = RD_LO;
          base_nxt     = PCIn;
          mem_addr_nxt = PCIn;
          mem_read_nxt = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_nxt = '0;
`endif
        end
      end

      RD_LO: begin
        if (MemValid) begin
          state_nxt    = RD_HI;
          ir_data_nxt  = MemData;
          ir_write_nxt = 1'b1;
          irlh_nxt     = 1'b0;
          mem_addr_nxt = base + ADDR_W'(1);
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_nxt = '0;
        end else if (wait_expired) begin
          state_nxt    = IDLE;
          mem_read_nxt = 1'b0;
          error_nxt    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
`endif
        end
      end

      RD_HI: begin
        if (MemValid) begin
          state_nxt    = WR_HI;
          ir_data_nxt  = MemData;
          ir_write_nxt = 1'b1;
          irlh_nxt     = 1'b1;
          mem_read_nxt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        end else if (wait_expired) begin
          state_nxt    = IDLE;
          mem_read_nxt = 1'b0;
          error_nxt    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
`endif
        end
      end

      WR_HI: begin
        // First WR_HI cycle carries the high strobe; leave after the quiet one.
        if (!IRWrite) begin
          state_nxt   = DONE;
          done_nxt    = 1'b1;
          next_pc_nxt = base + ADDR_W'(2);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      base     <= '0;
      MemAddr  <= '0;
      MemRead  <= 1'b0;
      IRData   <= '0;
      IRWrite  <= 1'b0;
      IRLH     <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      NextPC   <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt <= '0;
      Error    <= 1'b0;
`endif
    end else begin
      base     <= base_nxt;
      MemAddr  <= mem_addr_nxt;
      MemRead  <= mem_read_nxt;
      IRData   <= ir_data_nxt;
      IRWrite  <= ir_write_nxt;
      IRLH     <= irlh_nxt;
      Busy     <= busy_nxt;
      Done     <= done_nxt;
      NextPC   <= next_pc_nxt;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt <= wait_cnt_nxt;
      Error    <= error_nxt;
`endif
    end
  end

endmodule

// File: doc/instruction_fetch_sequencer.md
Name: instruction_fetch_sequencer

Overview:
Writer side of the byte-wide instruction-register load interface. On a fetch request it reads two consecutive bytes from 8-bit memory, low byte first. It presents each byte to the instruction register with a one-cycle write strobe and the low/high half-select. It then reports completion and the next sequential PC.

Parameters:
ADDR_W, 16, width of the memory address and PC.
DATA_W, 8, memory and IR byte-bus width; fixed at 8; the IR word is 2*DATA_W.
TIMEOUT, 15, cycles to wait for MemValid before aborting; used only with FETCH_TIMEOUT_EN.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  synchronous, active-high reset.
Start  input  1  fetch request; sampled only in IDLE.
PCIn  input  ADDR_W  address of the low instruction byte; captured when Start is accepted.
MemAddr  output  ADDR_W  memory read address.
MemRead  output  1  memory read request; held until MemValid.
MemData  input  DATA_W  memory read data; valid when MemValid=1.
MemValid  input  1  read data valid; honoured only while MemRead=1.
IRData  output  DATA_W  byte driven to the IR input bus.
IRWrite  output  1  one-cycle IR write strobe.
IRLH  output  1  IR half-select: 0 = bits [7:0], 1 = bits [15:8].
Busy  output  1  high in every non-IDLE state.
Done  output  1  one-cycle pulse when both halves are written.
NextPC  output  ADDR_W  PCIn+2 mod 2^ADDR_W; updated when Done pulses.
Error  output  1  timeout flag; exists only with FETCH_TIMEOUT_EN.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, internal base address 0.
- States: IDLE, RD_LO, RD_HI, WR_HI, DONE.
- IDLE:
  - Start=1: capture base=PCIn, go to RD_LO.
  - Start=0: stay in IDLE.
- RD_LO:
  - MemRead=1, MemAddr=base.
  - On the edge where MemValid=1: next cycle IRData=MemData, IRWrite=1, IRLH=0; state RD_HI with MemAddr=base+1, MemRead=1.
- RD_HI:
  - IRWrite returns to 0 after its single cycle.
  - On the edge where MemValid=1: next cycle IRData=MemData, IRWrite=1, IRLH=1, MemRead=0, state WR_HI.
- WR_HI: one cycle with IRWrite=0; go to DONE.
- DONE: Done=1 for one cycle, NextPC=base+2; go to IDLE.
- Minimum latency, with MemValid returned on the first cycle of each read:
  - Start accepted at edge 0.
  - Low-byte write strobe in cycle 2.
  - High-byte write strobe in cycle 3.
  - Done in cycle 5.
- Address arithmetic is modulo 2^ADDR_W: base=0xFFFF reads 0xFFFF then 0x0000; NextPC=0x0001.
- Start while Busy=1 (including the DONE cycle) is ignored; it is not queued.
- MemValid while MemRead=0 is ignored.
- MemRead is deasserted the cycle after the high-byte MemValid; no back-to-back reads without a new Start.
- IRData holds its last byte when IRWrite=0. IRLH holds its last value when IRWrite=0.
- Reset during any state:
  - Next cycle: IDLE, IRWrite=0, MemRead=0, Done=0.
  - A partial IR load is abandoned; no further strobes are issued.
- Reset and Start asserted together: Reset wins.

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined:
  - A per-read wait counter resets on entering RD_LO and on entering RD_HI.
  - If TIMEOUT cycles elapse with MemValid=0: drop MemRead, issue no further IRWrite, pulse Error=1 for one cycle (Done stays 0), return to IDLE.
  - A low byte already written stays in the IR.
- Undefined:
  - The Error port and counter are absent.
  - The sequencer waits indefinitely for MemValid.

Test Plan:
- Basic fetch: PCIn=0x0010, memory [0x0010]=0x34, [0x0011]=0x12, MemValid returned immediately -> strobe (IRLH=0, 0x34) in cycle 2, strobe (IRLH=1, 0x12) in cycle 3, Done in cycle 5, NextPC=0x0012; a bench IR model holds 0x1234.
- Wait states: MemValid delayed 3 cycles on each read -> MemRead and MemAddr held stable throughout; exactly two IRWrite pulses; correct word loaded.
- Wrap: PCIn=0xFFFF -> MemAddr sequence 0xFFFF, 0x0000; NextPC=0x0001.
- Start ignored: Start pulsed in RD_HI and in DONE -> no new fetch; Busy drops after Done; a later Start in IDLE is accepted.
- Reset mid-fetch: Reset in RD_HI after the low strobe -> next cycle IDLE with all outputs 0; no high strobe; Done never pulses.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT=4): MemValid never asserted in RD_LO -> Error pulse at cycle 4 of waiting, zero IRWrite pulses, Busy=0 the following cycle.
